// File: rtl/joypad_scanner.sv
// Serial NES/SNES joypad scanner: latches and clocks NUM_PADS shift-register
// pads in parallel and publishes an active-high button vector per scan.
`timescale 1ns/1ps
module joypad_scanner #(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 8,
    parameter int CLK_DIV     = 150,
    parameter int AUTO_SCAN   = 1,
    parameter int SCAN_PERIOD = 420000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_PADS-1:0]          jp_data,
    output logic                         jp_latch,
    output logic                         jp_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         valid,
    output logic                         changed,
    output logic                         busy
);

    localparam int BTN_W = NUM_PADS * NUM_BITS;
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int PER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    localparam logic [DIV_W-1:0] LATCH_END = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_END  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NUM_BITS - 1);
    localparam logic [PER_W-1:0] PER_END   = PER_W'(SCAN_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } state_t;

    state_t              state_q;
    logic                latch_q;
    logic                jclk_q;
    logic [DIV_W-1:0]    div_q;
    logic [BIT_W-1:0]    bit_q;
    logic [BTN_W-1:0]    shadow_q;
    logic [BTN_W-1:0]    shadow_d;
    logic [BTN_W-1:0]    buttons_q;
    logic                valid_q;
    logic                changed_q;
    logic                busy_q;
    logic                pend_q;
    logic [NUM_PADS-1:0] meta_q;
    logic [NUM_PADS-1:0] sync_q;
    logic [PER_W-1:0]    per_q;
    logic [PER_W-1:0]    per_d;
    logic                auto_hit;

    // Pad lines are asynchronous; only sync_q is ever sampled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= jp_data;
            sync_q <= meta_q;
        end
    end

    always_comb begin
        per_d = '0;
        if (AUTO_SCAN != 0 && per_q != PER_END) begin
            per_d = per_q + 1'b1;
        end
    end

    assign auto_hit = (AUTO_SCAN != 0) && (per_q == PER_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    function automatic logic [NUM_BITS-1:0] shift_in(
        input logic [NUM_BITS-1:0] v,
        input logic                b
    );
        logic [NUM_BITS-1:0] r;
        r = v >> 1;
        r[NUM_BITS-1] = b;
        return r;
    endfunction

    // First bit shifted in ends up at index 0 after NUM_BITS samples.
    always_comb begin
        shadow_d = shadow_q;
        for (int p = 0; p < NUM_PADS; p++) begin
            shadow_d[p*NUM_BITS +: NUM_BITS] =
                shift_in(shadow_q[p*NUM_BITS +: NUM_BITS], ~sync_q[p]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            latch_q   <= 1'b0;
            jclk_q    <= 1'b1;
            div_q     <= '0;
            bit_q     <= '0;
            shadow_q  <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            // Auto trigger during a scan is held until the next idle cycle.
            if (state_q != IDLE && auto_hit) begin
                pend_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start || auto_hit || pend_q) begin
                        state_q <= LATCH;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                        pend_q  <= 1'b0;
                    end
                end
                LATCH: begin
                    if (div_q == LATCH_END) begin
                        shadow_q <= shadow_d;
                        latch_q  <= 1'b0;
                        div_q    <= '0;
                        bit_q    <= BIT_W'(1);
                        if (NUM_BITS > 1) begin
                            state_q <= CLK_LO;
                            jclk_q  <= 1'b0;
                        end else begin
                            state_q <= DONE;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                CLK_LO: begin
                    if (div_q == HALF_END) begin
                        state_q <= CLK_HI;
                        jclk_q  <= 1'b1;
                        div_q   <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                CLK_HI: begin
                    if (div_q == HALF_END) begin
                        shadow_q <= shadow_d;
                        div_q    <= '0;
                        if (bit_q == LAST_BIT) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= CLK_LO;
                            jclk_q  <= 1'b0;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                DONE: begin
                    buttons_q <= shadow_q;
                    valid_q   <= 1'b1;
                    changed_q <= (shadow_q != buttons_q);
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign jp_latch = latch_q;
    assign jp_clk   = jclk_q;
    assign buttons  = buttons_q;
    assign valid    = valid_q;
    assign changed  = changed_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_joypad_scanner.sv
// Scoreboard bench: behavioural pad models, a manual-start 2x8 scanner
// and a free-running 1x16 scanner checked by independent monitors.
`timescale 1ns/1ps
module tb_joypad_scanner;

    localparam int CD    = 4;
    localparam int AP    = 200;
    localparam int LAT8  = 2 * CD * 8 + 1;
    localparam int LAT16 = 2 * CD * 16 + 1;

    typedef struct {
        logic [15:0] btn;
        logic        chg;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;
    int rel_cyc = 0;
    int n_auto = 0;
    logic [15:0] model_m = '0;
    exp_t sb_m[$];
    exp_t sb_a[$];

    logic        rst_m, start_m, latch_m, jclk_m, valid_m, chg_m, busy_m;
    logic [1:0]  data_m;
    logic [15:0] btn_m;
    logic        rst_a, start_a, latch_a, jclk_a, valid_a, chg_a, busy_a;
    logic [0:0]  data_a;
    logic [15:0] btn_a;

    joypad_scanner #(
        .NUM_PADS(2), .NUM_BITS(8), .CLK_DIV(CD),
        .AUTO_SCAN(0), .SCAN_PERIOD(AP)
    ) u_man (
        .clk(clk), .reset(rst_m), .start(start_m), .jp_data(data_m),
        .jp_latch(latch_m), .jp_clk(jclk_m), .buttons(btn_m),
        .valid(valid_m), .changed(chg_m), .busy(busy_m)
    );

    joypad_scanner #(
        .NUM_PADS(1), .NUM_BITS(16), .CLK_DIV(CD),
        .AUTO_SCAN(1), .SCAN_PERIOD(AP)
    ) u_auto (
        .clk(clk), .reset(rst_a), .start(start_a), .jp_data(data_a),
        .jp_latch(latch_a), .jp_clk(jclk_a), .buttons(btn_a),
        .valid(valid_a), .changed(chg_a), .busy(busy_a)
    );

    // Pads: latch reloads the bit pointer, each jp_clk rise advances it.
    logic [1:0][7:0] pat_m = '1;
    int idx_m = 0;
    always @(posedge jclk_m or posedge latch_m)
        idx_m <= latch_m ? 0 : idx_m + 1;
    always_comb begin
        for (int p = 0; p < 2; p++)
            data_m[p] = (idx_m < 8) ? pat_m[p][idx_m[2:0]] : 1'b0;
    end

    logic [15:0] pat_a = 16'h5A5A;
    int idx_a = 0;
    always @(posedge jclk_a or posedge latch_a)
        idx_a <= latch_a ? 0 : idx_a + 1;
    always_comb data_a[0] = (idx_a < 16) ? pat_a[idx_a[3:0]] : 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    initial begin : mon_m
        exp_t e;
        int lat_run, lo_run, lo_cnt;
        lat_run = 0; lo_run = 0; lo_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_m) begin
                lat_run = 0;
                lo_run = 0;
            end else begin
                if (latch_m) begin
                    if (lat_run == 0) lo_cnt = 0;
                    lat_run++;
                end else if (lat_run != 0) begin
                    chk("latch_width", lat_run, 2 * CD);
                    lat_run = 0;
                end
                if (!jclk_m) begin
                    lo_run++;
                end else if (lo_run != 0) begin
                    chk("jpclk_low_width", lo_run, CD);
                    lo_cnt++;
                    lo_run = 0;
                end
                if (valid_m) begin
                    chk("jpclk_pulse_count", lo_cnt, 7);
                    if (sb_m.size() == 0) begin
                        nchk++; nerr++;
                        $display("FAIL unexpected_valid: got valid=1 required 0 at cycle %0d", cyc);
                    end else begin
                        e = sb_m.pop_front();
                        chk("buttons", btn_m, e.btn);
                        chk("changed", chg_m, e.chg);
                        chk("latency", cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin : mon_a
        exp_t e;
        logic lat_prev, busy_prev;
        int last_rise;
        logic [15:0] model_a;
        lat_prev = 1'b0; busy_prev = 1'b0; last_rise = -1; model_a = '0;
        forever begin
            @(negedge clk);
            if (rst_a) begin
                last_rise = -1;
                model_a = '0;
                sb_a.delete();
            end else begin
                if (latch_a && !lat_prev) begin
                    if (last_rise < 0) chk("auto_first_launch", cyc, rel_cyc + AP);
                    else chk("auto_period", cyc - last_rise, AP);
                    chk("auto_busy_before_launch", busy_prev, 0);
                    last_rise = cyc;
                    e.btn = ~pat_a;
                    e.chg = (e.btn != model_a);
                    e.due = cyc + LAT16;
                    model_a = e.btn;
                    sb_a.push_back(e);
                end
                if (valid_a) begin
                    if (sb_a.size() == 0) begin
                        nchk++; nerr++;
                        $display("FAIL auto_unexpected_valid: got valid=1 required 0 at cycle %0d", cyc);
                    end else begin
                        e = sb_a.pop_front();
                        chk("auto_buttons", btn_a, e.btn);
                        chk("auto_changed", chg_a, e.chg);
                        chk("auto_latency", cyc, e.due);
                    end
                    n_auto++;
                    pat_a = 16'($urandom);
                end
            end
            lat_prev = latch_a;
            busy_prev = busy_a;
        end
    end

    task automatic do_scan(input logic [7:0] p0, input logic [7:0] p1,
                           input bit poke);
        exp_t e;
        @(negedge clk);
        pat_m[0] = p0;
        pat_m[1] = p1;
        start_m = 1'b1;
        e.btn = ~{p1, p0};
        e.chg = (e.btn != model_m);
        e.due = cyc + 1 + LAT8;
        model_m = e.btn;
        sb_m.push_back(e);
        @(negedge clk);
        start_m = 1'b0;
        chk("busy_after_start", busy_m, 1);
        if (poke) begin
            repeat (20) @(negedge clk);
            start_m = 1'b1;
            @(negedge clk);
            start_m = 1'b0;
        end
        for (int w = 0; w < 200 && sb_m.size() != 0; w++) @(negedge clk);
        if (sb_m.size() != 0) begin
            nchk++; nerr++;
            $display("FAIL scan_timeout: got no valid, required one (%0d pending)", sb_m.size());
            sb_m.delete();
        end
        repeat (4) @(negedge clk);
        chk("busy_idle", busy_m, 0);
    endtask

    initial begin : main
        logic [7:0] a, b;
        int n0;
        rst_m = 1'b1;
        rst_a = 1'b1;
        start_m = 1'b0;
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_latch", latch_m, 0);
        chk("rst_jpclk", jclk_m, 1);
        chk("rst_buttons", btn_m, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_changed", chg_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_auto_outs", {latch_a, jclk_a, busy_a}, 3'b010);
        rel_cyc = cyc;
        rst_a = 1'b0;
        rst_m = 1'b0;
        repeat (3) @(negedge clk);

        do_scan(8'hFE, 8'hFF, 0);
        do_scan(8'hFE, 8'hFF, 1);
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            do_scan(a, b, (i % 3) == 1);
            if (i == 4) do_scan(a, b, 0);
        end
        do_scan(8'h00, 8'h00, 0);

        @(negedge clk);
        pat_m[0] = 8'($urandom);
        pat_m[1] = 8'($urandom);
        start_m = 1'b1;
        n0 = cyc + 1;
        @(negedge clk);
        start_m = 1'b0;
        while (cyc < n0 + 29) @(negedge clk);
        chk("pre_reset_clk_hi", {busy_m, jclk_m}, 2'b11);
        #1 rst_m = 1'b1;
        #1;
        chk("abort_latch", latch_m, 0);
        chk("abort_jpclk", jclk_m, 1);
        chk("abort_buttons", btn_m, 0);
        chk("abort_busy", busy_m, 0);
        chk("abort_valid", valid_m, 0);
        repeat (2) @(negedge clk);
        rst_m = 1'b0;
        model_m = '0;
        repeat (80) @(negedge clk);
        do_scan(8'hFE, 8'hFF, 0);

        for (int w = 0; w < 3000 && cyc < 2000; w++) @(negedge clk);
        chk("auto_scan_count", n_auto >= 8, 1);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/joypad_scanner.md
JOYPAD_SCANNER -- requirements
Module: joypad_scanner

Interface
REQ-001 Parameter NUM_PADS, default 2: number of serial joypad ports scanned in parallel, legal 1..4.
REQ-002 Parameter NUM_BITS, default 8: bits shifted per pad per scan, legal 8 (NES) or 16 (SNES-style).
REQ-003 Parameter CLK_DIV, default 150: clk cycles per jp_clk half-period and per latch half-width, legal >= 4.
REQ-004 Parameter AUTO_SCAN, default 1: 1 = free-running scans every SCAN_PERIOD cycles; 0 = scan only on start.
REQ-005 Parameter SCAN_PERIOD, default 420000: clk cycles between auto-scan launches, legal > scan length.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  scan request, sampled each cycle.
REQ-009 jp_data  input  NUM_PADS  serial data from pads, active-low buttons, asynchronous to clk.
REQ-010 jp_latch  output  1  parallel-load strobe shared by all pads.
REQ-011 jp_clk  output  1  shift clock shared by all pads, idles high.
REQ-012 buttons  output  NUM_PADS*NUM_BITS  pressed=1; pad p bit i at index p*NUM_BITS+i, bit 0 = first bit shifted out.
REQ-013 valid  output  1  one-cycle pulse when buttons updates.
REQ-014 changed  output  1  one-cycle pulse, coincident with valid, when new buttons differ from previous value.
REQ-015 busy  output  1  high while a scan is in progress.

Function
REQ-016 jp_data SHALL pass through a 2-flop synchronizer per pad before any use.
REQ-017 States: IDLE, LATCH, CLK_LO, CLK_HI, DONE.
REQ-018 IDLE -> LATCH when start=1 or (AUTO_SCAN=1 and period counter reaches SCAN_PERIOD-1); period counter then reloads to 0.
REQ-019 LATCH: jp_latch=1 for exactly 2*CLK_DIV cycles; last cycle samples bit 0 of each pad; then CLK_LO if NUM_BITS>1.
REQ-020 CLK_LO: jp_clk=0 for CLK_DIV cycles, then CLK_HI.
REQ-021 CLK_HI: jp_clk=1 for CLK_DIV cycles; last cycle samples next bit of each pad; after bit NUM_BITS-1 go DONE, else CLK_LO.
REQ-022 Samples SHALL be inverted (active-low to pressed=1) and shifted into a per-pad shadow register; buttons SHALL not change mid-scan.
REQ-023 DONE lasts one cycle: buttons <= shadow, valid=1, changed=1 iff shadow != previous buttons; then IDLE.
REQ-024 Scan latency: start sampled at edge N -> valid high in the cycle beginning at edge N + 2*CLK_DIV*NUM_BITS + 1.
REQ-025 busy=1 in LATCH, CLK_LO, CLK_HI, DONE; 0 in IDLE.
REQ-026 start while busy SHALL be ignored, not queued; auto-scan trigger while busy SHALL be deferred to the first IDLE cycle.
REQ-027 Period counter SHALL run continuously in AUTO_SCAN=1, including during scans, and wrap at SCAN_PERIOD-1.
REQ-028 jp_latch and jp_clk SHALL be driven directly from flops (glitch-free).

Reset
REQ-029 On reset assertion, asynchronously: state=IDLE, jp_latch=0, jp_clk=1, buttons=0, shadow=0, valid=0, changed=0, busy=0, all counters and synchronizers 0.
REQ-030 Reset mid-scan SHALL abort the scan with no valid pulse; first scan after release starts from LATCH with a full latch pulse.
REQ-031 After reset release with AUTO_SCAN=1, the first auto-scan SHALL launch SCAN_PERIOD cycles after release.

Verification
REQ-032 NUM_PADS=2, NUM_BITS=8, CLK_DIV=4, AUTO_SCAN=0; pad0 models 0xFE pattern (A pressed), pad1 all released; pulse start -> jp_latch high 8 cycles, 7 jp_clk low pulses of 4 cycles, valid 65 cycles after start, buttons=16'h0001, changed=1.
REQ-033 Same config, repeat identical scan -> valid=1, changed=0, buttons unchanged; start asserted during scan -> no second scan, exactly one valid.
REQ-034 NUM_BITS=16, NUM_PADS=1, pad pattern 16'h5A5A (inverted data) -> buttons=16'hA5A5 after 2*4*16+1=129 cycles.
REQ-035 AUTO_SCAN=1, SCAN_PERIOD=200, CLK_DIV=4 -> jp_latch rising edges exactly 200 cycles apart, busy never overlaps two scans.
REQ-036 Assert reset during CLK_HI of bit 3 -> jp_latch=0, jp_clk=1, buttons=0 immediately, no valid; subsequent start completes normally.
